ahf_link_master_port: RTL

// Master-side endpoint of the inter-core data link that feeds a RISC521 slave core.
// - Host side: master core issues single-word writes (push to slave) and reads (pull from slave).
// - Link side: drives the slave's Data_in/Read/Write and watches its Data_out/Done_out.
// - A one-word transfer finishes only after the slave parks on its I/O port (Done high) and then releases it (Done low).

---
 rtl/ahf_link_master_port.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ahf_link_master_port.sv
// ahf_link_master_port
// Master-side endpoint of the inter-core link feeding a RISC521 slave core.
// The master core issues single-word writes (push) and reads (pull); each
// link transfer completes only after the slave raises Done and then drops it.
// A write and read requested together run back to back, write first, with
// Host_Busy held high across both.
// Optional feature: define AHF_LINK_TIMEOUT_EN to abort a transfer whose
// wait states last TIMEOUT_CYC cycles; without it the port waits forever and
// Host_Err is tied low.

module ahf_link_master_port #(
    parameter int DATA_W      = 14,
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 10
) (
    input  logic              Clk_pin0,
    input  logic              Reset_pin,
    input  logic              Host_WrReq,
    input  logic [DATA_W-1:0] Host_WrData,
    input  logic              Host_RdReq,
    output logic              Host_Busy,
    output logic [DATA_W-1:0] Host_RdData,
    output logic              Host_RdValid,
    output logic              Host_Err,
    output logic [DATA_W-1:0] Link_Data_out,
    output logic              Link_Write,
    output logic              Link_Read,
    input  logic [DATA_W-1:0] Link_Data_in,
    input  logic              Link_Done,
    output logic [13:0]       Link_XferCnt
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_REL,
        RD_WAIT,
        RD_REL
    } state_t;

    state_t            state, state_nxt;
    logic              rd_pend, rd_pend_nxt;
    logic              busy_nxt;
    logic              write_nxt;
    logic              read_nxt;
    logic              rd_valid_nxt;
    logic [DATA_W-1:0] rd_data_nxt;
    logic [DATA_W-1:0] data_out_nxt;
    logic [13:0]       xfer_cnt_nxt;

`ifdef AHF_LINK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt;
    logic              err_nxt;
`endif

    // Next-state and next-output logic; every output is a register fed from here.
    always_comb begin
        state_nxt    = state;
        rd_pend_nxt  = rd_pend;
        busy_nxt     = Host_Busy;
        write_nxt    = Link_Write;
        read_nxt     = Link_Read;
        rd_valid_nxt = 1'b0;
        rd_data_nxt  = Host_RdData;
        data_out_nxt = Link_Data_out;
        xfer_cnt_nxt = Link_XferCnt;
`ifdef AHF_LINK_TIMEOUT_EN
        tmo_cnt_nxt  = '0;
        err_nxt      = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (rd_pend) begin
                    read_nxt    = 1'b1;
                    busy_nxt    = 1'b1;
                    rd_pend_nxt = 1'b0;
                    state_nxt   = RD_WAIT;
                end else if (Host_WrReq) begin
                    data_out_nxt = Host_WrData;
                    write_nxt    = 1'b1;
                    busy_nxt     = 1'b1;
                    rd_pend_nxt  = Host_RdReq;
                    state_nxt    = WR_WAIT;
                end else if (Host_RdReq) begin
                    read_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (Link_Done) begin
                    state_nxt = WR_REL;
                end
            end
            WR_REL: begin
                if (!Link_Done) begin
                    write_nxt    = 1'b0;
                    xfer_cnt_nxt = Link_XferCnt + 14'd1;
                    busy_nxt     = rd_pend;
                    state_nxt    = IDLE;
                end
            end
            RD_WAIT: begin
                if (Link_Done) begin
                    rd_data_nxt  = Link_Data_in;
                    rd_valid_nxt = 1'b1;
                    state_nxt    = RD_REL;
                end
            end
            RD_REL: begin
                if (!Link_Done) begin
                    read_nxt     = 1'b0;
                    xfer_cnt_nxt = Link_XferCnt + 14'd1;
                    busy_nxt     = rd_pend;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef AHF_LINK_TIMEOUT_EN
        if (state != IDLE && state_nxt == state) begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
        if (state != IDLE && tmo_cnt == TMO_LIMIT) begin
            state_nxt    = IDLE;
            write_nxt    = 1'b0;
            read_nxt     = 1'b0;
            busy_nxt     = 1'b0;
            rd_pend_nxt  = 1'b0;
            rd_valid_nxt = 1'b0;
            rd_data_nxt  = Host_RdData;
            xfer_cnt_nxt = Link_XferCnt;
            tmo_cnt_nxt  = '0;
            err_nxt      = 1'b1;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk_pin0) begin
        if (Reset_pin) begin
            state         <= IDLE;
            rd_pend       <= 1'b0;
            Host_Busy     <= 1'b0;
            Host_RdData   <= '0;
            Host_RdValid  <= 1'b0;
            Link_Data_out <= '0;
            Link_Write    <= 1'b0;
            Link_Read     <= 1'b0;
            Link_XferCnt  <= '0;
        end else begin
            state         <= state_nxt;
            rd_pend       <= rd_pend_nxt;
            Host_Busy     <= busy_nxt;
            Host_RdData   <= rd_data_nxt;
            Host_RdValid  <= rd_valid_nxt;
            Link_Data_out <= data_out_nxt;
            Link_Write    <= write_nxt;
            Link_Read     <= read_nxt;
            Link_XferCnt  <= xfer_cnt_nxt;
        end
    end

`ifdef AHF_LINK_TIMEOUT_EN
    // Wait-state cycle counter and the one-cycle abort pulse.
    always_ff @(posedge Clk_pin0) begin
        if (Reset_pin) begin
            tmo_cnt  <= '0;
            Host_Err <= 1'b0;
        end else begin
            tmo_cnt  <= tmo_cnt_nxt;
            Host_Err <= err_nxt;
        end
    end
`else
    assign Host_Err = 1'b0;
`endif

endmodule
